mem_access_unit: RTL and testbench



---
 rtl/mem_access_unit.sv | 198 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store front-end between the CPU datapath and the Avalon bridge:
// builds lane data/byteenables, runs one bus access, returns load data.
module mem_access_unit #(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] rt_data,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        addr_err,
    output logic [31:0] address,
    output logic [31:0] write_data,
    output logic [3:0]  byteenable,
    output logic        read_select,
    output logic        write_select,
    input  logic [31:0] read_data,
    input  logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0] OP_LB  = 4'd0;
    localparam logic [3:0] OP_LBU = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LW  = 4'd4;
    localparam logic [3:0] OP_LWL = 4'd5;
    localparam logic [3:0] OP_LWR = 4'd6;
    localparam logic [3:0] OP_SB  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SW  = 4'd10;
    localparam logic [3:0] OP_SWL = 4'd11;
    localparam logic [3:0] OP_SWR = 4'd12;

    state_t      state_q;
    logic [3:0]  op_q;
    logic [1:0]  k_q;
    logic [31:0] rt_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic        addr_err_q;
    logic        rsel_q;
    logic        wsel_q;
    logic [31:0] resp_data_q;
    logic [31:0] address_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;

    logic        legal_d;
    logic        store_d;
    logic        misalign_d;
    logic [1:0]  k_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [4:0]  sh_lo;
    logic [4:0]  sh_hi;

    // k_d is the lane actually used: half/word ops snap to their aligned lane
    always_comb begin
        legal_d    = 1'b1;
        store_d    = op[3];
        misalign_d = 1'b0;
        k_d        = addr[1:0];
        be_d       = 4'b1111;
        wdata_d    = rt_data;
        sh_lo      = {addr[1:0], 3'b000};
        sh_hi      = {~addr[1:0], 3'b000};
        unique case (op)
            OP_LB, OP_LBU: be_d = 4'b0001 << k_d;
            OP_SB: begin
                be_d    = 4'b0001 << k_d;
                wdata_d = {4{rt_data[7:0]}};
            end
            OP_LH, OP_LHU, OP_SH: begin
                misalign_d = ALIGN_CHECK && addr[0];
                k_d        = {addr[1], 1'b0};
                be_d       = addr[1] ? 4'b1100 : 4'b0011;
                if (op == OP_SH) wdata_d = {2{rt_data[15:0]}};
            end
            OP_LW, OP_SW: begin
                misalign_d = ALIGN_CHECK && (addr[1:0] != 2'b00);
                k_d        = 2'b00;
            end
            OP_LWL: be_d = 4'b1111 >> ~k_d;
            OP_LWR: be_d = 4'b1111 << k_d;
            OP_SWL: begin
                be_d    = 4'b1111 >> ~k_d;
                wdata_d = rt_data >> sh_hi;
            end
            OP_SWR: begin
                be_d    = 4'b1111 << k_d;
                wdata_d = rt_data << sh_lo;
            end
            default: legal_d = 1'b0;
        endcase
    end

    logic [31:0] load_d;
    logic [4:0]  lsh_lo;
    logic [4:0]  lsh_hi;
    logic [7:0]  lbyte;
    logic [15:0] lhalf;

    always_comb begin
        lsh_lo = {k_q, 3'b000};
        lsh_hi = {~k_q, 3'b000};
        lbyte  = 8'(read_data >> lsh_lo);
        lhalf  = k_q[1] ? read_data[31:16] : read_data[15:0];
        load_d = '0;
        unique case (op_q)
            OP_LB:   load_d = {{24{lbyte[7]}}, lbyte};
            OP_LBU:  load_d = {24'b0, lbyte};
            OP_LH:   load_d = {{16{lhalf[15]}}, lhalf};
            OP_LHU:  load_d = {16'b0, lhalf};
            OP_LW:   load_d = read_data;
            OP_LWL:  load_d = (read_data << lsh_hi)
                            | (rt_q & ~(32'hFFFF_FFFF << lsh_hi));
            OP_LWR:  load_d = (read_data >> lsh_lo)
                            | (rt_q & ~(32'hFFFF_FFFF >> lsh_lo));
            default: load_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_q         <= '0;
            k_q          <= '0;
            rt_q         <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            addr_err_q   <= 1'b0;
            address_q    <= '0;
            wdata_q      <= '0;
            be_q         <= 4'b1111;
            rsel_q       <= 1'b0;
            wsel_q       <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            rsel_q       <= 1'b0;
            wsel_q       <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        op_q        <= op;
                        k_q         <= k_d;
                        rt_q        <= rt_data;
                        req_ready_q <= 1'b0;
                        if (!legal_d || misalign_d) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            addr_err_q   <= 1'b1;
                            resp_data_q  <= '0;
                        end else begin
                            state_q   <= ISSUE;
                            address_q <= {addr[31:2], 2'b00};
                            be_q      <= be_d;
                            wdata_q   <= wdata_d;
                            rsel_q    <= !store_d;
                            wsel_q    <= store_d;
                        end
                    end
                end
                ISSUE: state_q <= WAIT;
                WAIT: begin
                    if (!busy) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        addr_err_q   <= 1'b0;
                        resp_data_q  <= load_d;
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready    = req_ready_q;
    assign resp_valid   = resp_valid_q;
    assign resp_data    = resp_data_q;
    assign addr_err     = addr_err_q;
    assign address      = address_q;
    assign write_data   = wdata_q;
    assign byteenable   = be_q;
    assign read_select  = rsel_q;
    assign write_select = wsel_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: reset, loads, stores, bus stalls,
// unaligned merges, error path, relaxed alignment and back-to-back ops.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_valid0 = 1'b0;
    logic [3:0]  op = '0;
    logic [31:0] addr = '0;
    logic [31:0] rt_data = '0;
    logic [31:0] read_data = '0;
    logic        busy = 1'b0;

    logic        req_ready, resp_valid, addr_err, read_select, write_select;
    logic [31:0] resp_data, address, write_data;
    logic [3:0]  byteenable;
    logic        req_ready0, resp_valid0, addr_err0, read_select0, write_select0;
    logic [31:0] resp_data0, address0, write_data0;
    logic [3:0]  byteenable0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ALIGN_CHECK(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .op(op), .addr(addr), .rt_data(rt_data),
        .resp_valid(resp_valid), .resp_data(resp_data), .addr_err(addr_err),
        .address(address), .write_data(write_data), .byteenable(byteenable),
        .read_select(read_select), .write_select(write_select),
        .read_data(read_data), .busy(busy)
    );

    mem_access_unit #(.ALIGN_CHECK(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid0), .req_ready(req_ready0),
        .op(op), .addr(addr), .rt_data(rt_data),
        .resp_valid(resp_valid0), .resp_data(resp_data0), .addr_err(addr_err0),
        .address(address0), .write_data(write_data0), .byteenable(byteenable0),
        .read_select(read_select0), .write_select(write_select0),
        .read_data(read_data), .busy(busy)
    );

    // Runs one op from IDLE; busy is held high for nbusy WAIT cycles.
    task automatic do_op(
        input  bit          u0,
        input  logic [3:0]  o,
        input  logic [31:0] a,
        input  logic [31:0] rt,
        input  logic [31:0] rd,
        input  int          nbusy,
        output logic [31:0] rdata,
        output logic        err,
        output logic [31:0] aout,
        output logic [3:0]  be,
        output logic [31:0] wd,
        output int          nrs,
        output int          nws,
        output int          selc,
        output int          lat
    );
        logic rv, rs, ws;
        rdata = '0; err = 1'b0; aout = '0; be = '0; wd = '0;
        nrs = 0; nws = 0; selc = -1; lat = -1;
        op = o; addr = a; rt_data = rt; read_data = rd; busy = 1'b0;
        if (u0) req_valid0 = 1'b1;
        else req_valid = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            req_valid0 = 1'b0;
            rv = u0 ? resp_valid0 : resp_valid;
            rs = u0 ? read_select0 : read_select;
            ws = u0 ? write_select0 : write_select;
            if (rs) nrs++;
            if (ws) nws++;
            if (rs || ws) begin
                selc = c;
                aout = u0 ? address0 : address;
                be   = u0 ? byteenable0 : byteenable;
                wd   = u0 ? write_data0 : write_data;
            end
            busy = (c >= 2) && (c < 2 + nbusy);
            if (rv) begin
                lat   = c;
                rdata = u0 ? resp_data0 : resp_data;
                err   = u0 ? addr_err0 : addr_err;
                break;
            end
        end
        busy = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        int nrv;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b exp 1", req_ready); end
        checks++; if (byteenable !== 4'b1111) begin errors++; $display("FAIL rst_be: got %b exp 1111", byteenable); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        op = 4'd4; addr = 32'h100; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        busy = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b exp 1", req_ready); end
        checks++; if (resp_valid !== 1'b0 || addr_err !== 1'b0) begin errors++; $display("FAIL mid_rst_resp: got %b/%b exp 0/0", resp_valid, addr_err); end
        checks++; if (resp_data !== 32'h0) begin errors++; $display("FAIL mid_rst_rdata: got %h exp 0", resp_data); end
        checks++; if (address !== 32'h0) begin errors++; $display("FAIL mid_rst_addr: got %h exp 0", address); end
        checks++; if (write_data !== 32'h0) begin errors++; $display("FAIL mid_rst_wd: got %h exp 0", write_data); end
        checks++; if (byteenable !== 4'b1111) begin errors++; $display("FAIL mid_rst_be: got %b exp 1111", byteenable); end
        checks++; if (read_select !== 1'b0 || write_select !== 1'b0) begin errors++; $display("FAIL mid_rst_sel: got %b%b exp 00", read_select, write_select); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        busy = 1'b0;
        nrv = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (resp_valid) nrv++;
        end
        checks++; if (nrv !== 0) begin errors++; $display("FAIL rst_drop: got %0d resp exp 0", nrv); end
    endtask

    task automatic test_lw;
        logic [31:0] rd, ao, wd; logic er; logic [3:0] be; int nr, nw, sc, lat;
        do_op(0, 4'd4, 32'h100, 32'h0, 32'hDEADBEEF, 0, rd, er, ao, be, wd, nr, nw, sc, lat);
        checks++; if (ao !== 32'h100) begin errors++; $display("FAIL lw_addr: got %h exp 100", ao); end
        checks++; if (be !== 4'b1111) begin errors++; $display("FAIL lw_be: got %b exp 1111", be); end
        checks++; if (nr !== 1 || nw !== 0 || sc !== 1) begin errors++; $display("FAIL lw_sel: got r%0d w%0d at %0d exp r1 w0 at 1", nr, nw, sc); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL lw_lat: got %0d exp 3", lat); end
        checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL lw_data: got %h/%b exp deadbeef/0", rd, er); end
    endtask

    task automatic test_loads;
        logic [31:0] rd, ao, wd; logic er; logic [3:0] be; int nr, nw, sc, lat;
        logic [3:0]  t_op [4];
        logic [31:0] t_a [4];
        logic [31:0] t_e [4];
        logic [3:0]  t_be [4];
        t_op = '{4'd0, 4'd1, 4'd2, 4'd3};
        t_a  = '{32'h203, 32'h203, 32'h202, 32'h200};
        t_e  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8081, 32'h0000F0F1};
        t_be = '{4'b1000, 4'b1000, 4'b1100, 4'b0011};
        for (int i = 0; i < 4; i++) begin
            do_op(0, t_op[i], t_a[i], 32'h0, 32'h8081F0F1, 0, rd, er, ao, be, wd, nr, nw, sc, lat);
            checks++; if (rd !== t_e[i] || lat !== 3) begin errors++; $display("FAIL load%0d: got %h lat %0d exp %h lat 3", i, rd, lat, t_e[i]); end
            checks++; if (be !== t_be[i] || ao !== 32'h200) begin errors++; $display("FAIL load%0d_be: got %b @%h exp %b @200", i, be, ao, t_be[i]); end
        end
    endtask

    task automatic test_stores;
        logic [31:0] rd, ao, wd; logic er; logic [3:0] be; int nr, nw, sc, lat;
        do_op(0, 4'd8, 32'h11, 32'h000000AB, 32'hFFFFFFFF, 0, rd, er, ao, be, wd, nr, nw, sc, lat);
        checks++; if (be !== 4'b0010 || ao !== 32'h10) begin errors++; $display("FAIL sb_be: got %b @%h exp 0010 @10", be, ao); end
        checks++; if (wd !== 32'hABABABAB) begin errors++; $display("FAIL sb_wd: got %h exp abababab", wd); end
        checks++; if (nw !== 1 || nr !== 0 || lat !== 3) begin errors++; $display("FAIL sb_sel: got w%0d r%0d lat %0d exp w1 r0 lat 3", nw, nr, lat); end
        checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL sb_resp: got %h/%b exp 0/0", rd, er); end
        do_op(0, 4'd9, 32'h12, 32'h00001234, 32'h0, 0, rd, er, ao, be, wd, nr, nw, sc, lat);
        checks++; if (be !== 4'b1100 || wd !== 32'h12341234) begin errors++; $display("FAIL sh: got %b %h exp 1100 12341234", be, wd); end
    endtask

    task automatic test_busy;
        logic [31:0] rd, ao, wd; logic er; logic [3:0] be; int nr, nw, sc, lat;
        do_op(0, 4'd10, 32'h20, 32'h55667788, 32'h0, 3, rd, er, ao, be, wd, nr, nw, sc, lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL busy_lat: got %0d exp 6", lat); end
        checks++; if (nw !== 1 || nr !== 0) begin errors++; $display("FAIL busy_sel: got w%0d r%0d exp w1 r0", nw, nr); end
        checks++; if (wd !== 32'h55667788 || be !== 4'b1111) begin errors++; $display("FAIL busy_wd: got %h %b exp 55667788 1111", wd, be); end
    endtask

    task automatic test_unaligned;
        logic [31:0] rd, ao, wd; logic er; logic [3:0] be; int nr, nw, sc, lat;
        do_op(0, 4'd5, 32'h301, 32'hAAAAAAAA, 32'h44332211, 0, rd, er, ao, be, wd, nr, nw, sc, lat);
        checks++; if (rd !== 32'h2211AAAA || be !== 4'b0011) begin errors++; $display("FAIL lwl: got %h %b exp 2211aaaa 0011", rd, be); end
        do_op(0, 4'd6, 32'h301, 32'hAAAAAAAA, 32'h44332211, 0, rd, er, ao, be, wd, nr, nw, sc, lat);
        checks++; if (rd !== 32'hAA443322 || be !== 4'b1110) begin errors++; $display("FAIL lwr: got %h %b exp aa443322 1110", rd, be); end
        do_op(0, 4'd12, 32'h302, 32'h0000BBCC, 32'h0, 0, rd, er, ao, be, wd, nr, nw, sc, lat);
        checks++; if (wd !== 32'hBBCC0000 || be !== 4'b1100) begin errors++; $display("FAIL swr: got %h %b exp bbcc0000 1100", wd, be); end
        do_op(0, 4'd11, 32'h301, 32'h11223344, 32'h0, 0, rd, er, ao, be, wd, nr, nw, sc, lat);
        checks++; if (wd !== 32'h00001122 || be !== 4'b0011) begin errors++; $display("FAIL swl: got %h %b exp 00001122 0011", wd, be); end
    endtask

    task automatic test_errors;
        logic [31:0] rd, ao, wd; logic er; logic [3:0] be; int nr, nw, sc, lat;
        do_op(0, 4'd4, 32'h102, 32'h0, 32'h12345678, 0, rd, er, ao, be, wd, nr, nw, sc, lat);
        checks++; if (er !== 1'b1 || lat !== 1) begin errors++; $display("FAIL mis_err: got %b lat %0d exp 1 lat 1", er, lat); end
        checks++; if (nr !== 0 || nw !== 0 || rd !== 32'h0) begin errors++; $display("FAIL mis_sel: got r%0d w%0d %h exp r0 w0 0", nr, nw, rd); end
        checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL err_hold: got %b exp 1", addr_err); end
        do_op(0, 4'd7, 32'h100, 32'h0, 32'h12345678, 0, rd, er, ao, be, wd, nr, nw, sc, lat);
        checks++; if (er !== 1'b1 || lat !== 1 || nr !== 0 || nw !== 0) begin errors++; $display("FAIL ill_op: got %b lat %0d r%0d w%0d exp 1 lat 1 r0 w0", er, lat, nr, nw); end
        do_op(0, 4'd9, 32'h13, 32'h0, 32'h0, 0, rd, er, ao, be, wd, nr, nw, sc, lat);
        checks++; if (er !== 1'b1 || nw !== 0) begin errors++; $display("FAIL sh_mis: got %b w%0d exp 1 w0", er, nw); end
    endtask

    task automatic test_align_off;
        logic [31:0] rd, ao, wd; logic er; logic [3:0] be; int nr, nw, sc, lat;
        do_op(1, 4'd4, 32'h102, 32'h0, 32'hCAFEF00D, 0, rd, er, ao, be, wd, nr, nw, sc, lat);
        checks++; if (er !== 1'b0 || lat !== 3 || nr !== 1) begin errors++; $display("FAIL noalign_lw: got %b lat %0d r%0d exp 0 lat 3 r1", er, lat, nr); end
        checks++; if (ao !== 32'h100 || be !== 4'b1111 || rd !== 32'hCAFEF00D) begin errors++; $display("FAIL noalign_lw_data: got %h %b %h exp 100 1111 cafef00d", ao, be, rd); end
        do_op(1, 4'd2, 32'h203, 32'h0, 32'h8081F0F1, 0, rd, er, ao, be, wd, nr, nw, sc, lat);
        checks++; if (rd !== 32'hFFFF8081 || be !== 4'b1100) begin errors++; $display("FAIL noalign_lh: got %h %b exp ffff8081 1100", rd, be); end
    endtask

    task automatic test_back_to_back;
        logic [3:0]  t_op [4];
        logic [31:0] t_a [4];
        logic [31:0] t_e [3];
        int idx, nresp, nsel, viol;
        logic rdy;
        t_op = '{4'd4, 4'd1, 4'd3, 4'd0};
        t_a  = '{32'h400, 32'h401, 32'h402, 32'h0};
        t_e  = '{32'h11223344, 32'h00000033, 32'h00001122};
        read_data = 32'h11223344;
        idx = 0; nresp = 0; nsel = 0; viol = 0;
        for (int c = 0; c < 60; c++) begin
            req_valid = (idx < 3);
            op = t_op[idx];
            addr = t_a[idx];
            rdy = req_ready;
            @(posedge clk); #1;
            if (rdy && req_valid) idx++;
            if (read_select || write_select) nsel++;
            if (req_ready && (read_select || write_select || resp_valid)) viol++;
            if (resp_valid) begin
                checks++; if (resp_data !== t_e[nresp]) begin errors++; $display("FAIL b2b_resp%0d: got %h exp %h", nresp, resp_data, t_e[nresp]); end
                nresp++;
            end
            if (nresp == 3) break;
        end
        req_valid = 1'b0;
        checks++; if (nresp !== 3) begin errors++; $display("FAIL b2b_count: got %0d exp 3", nresp); end
        checks++; if (nsel !== 3) begin errors++; $display("FAIL b2b_sel: got %0d exp 3", nsel); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL b2b_ready: got %0d exp 0", viol); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_loads();
        test_stores();
        test_busy();
        test_unaligned();
        test_errors();
        test_align_off();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
